// File: rtl/seg7_scan_ctrl_if.sv
// Bundle between the scan controller and its neighbours.
// The upstream source drives the display value (in_valid/in_data/in_blank).
// The controller drives the seg7 decoder inputs (seg_nib/seg_en), the digit
// enables (dig_sel_n) and the frame_done pulse.
//   master : upstream / observer side (drives in_*, reads outputs)
//   slave  : scan controller side
interface seg7_scan_ctrl_if #(
    parameter int P_DIGITS = 4
) ();
    logic                    in_valid;
    logic [4*P_DIGITS-1:0]   in_data;
    logic [P_DIGITS-1:0]     in_blank;
    logic [3:0]              seg_nib;
    logic                    seg_en;
    logic [P_DIGITS-1:0]     dig_sel_n;
    logic                    frame_done;

    modport master (
        output in_valid, in_data, in_blank,
        input  seg_nib, seg_en, dig_sel_n, frame_done
    );

    modport slave (
        input  in_valid, in_data, in_blank,
        output seg_nib, seg_en, dig_sel_n, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Each digit slot is P_BLANK all-dark cycles followed by P_DWELL SHOW cycles.
// The digit nibble and a load strobe go to a registered-output seg7 decoder on
// the first SHOW cycle; the digit select follows one cycle later so it lines up
// with the decoder's registered segments. New values are double-buffered and
// only take effect on a frame boundary, so a frame never tears.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   bus.slave   in_valid/in_data/in_blank in; seg_nib/seg_en/dig_sel_n/frame_done out
//
// state | meaning
// BLANK | all digits dark, anti-ghosting gap before a digit
// SHOW  | current digit driven (from the 2nd SHOW cycle on)
module seg7_scan_ctrl #(
    parameter int P_DIGITS = 4,
    parameter int P_DWELL  = 50000,
    parameter int P_BLANK  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_ctrl_if.slave   bus
);
    localparam int CNT_MAX = (P_DWELL > P_BLANK) ? P_DWELL : P_BLANK;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (P_DIGITS > 1) ? $clog2(P_DIGITS) : 1;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic [IW-1:0]           r_idx, w_idx_nxt;
    logic [4*P_DIGITS-1:0]   r_act_data, r_shd_data;
    logic [P_DIGITS-1:0]     r_act_blank, r_shd_blank;
    logic                    r_pending;
    logic [3:0]              r_seg_nib, w_nib_nxt;
    logic                    r_seg_en, w_en_nxt;
    logic [P_DIGITS-1:0]     r_dig_sel_n, w_sel_nxt;
    logic                    r_frame_done, w_fd_nxt;

    logic                    w_last_blank, w_last_show, w_idx_last, w_boundary;
    logic [3:0]              w_nib;
    logic                    w_dark;
    logic [P_DIGITS-1:0]     w_sel_mask;

    assign w_last_blank = (r_state == ST_BLANK) && (r_cnt == CW'(P_BLANK - 1));
    assign w_last_show  = (r_state == ST_SHOW)  && (r_cnt == CW'(P_DWELL - 1));
    assign w_idx_last   = (r_idx == IW'(P_DIGITS - 1));
    assign w_boundary   = w_last_show && w_idx_last;

    // Per-digit selection of the active nibble, blank flag and one-cold select.
    always_comb begin
        w_nib      = 4'h0;
        w_dark     = 1'b0;
        w_sel_mask = '1;
        for (int k = 0; k < P_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_nib         = r_act_data[4*k +: 4];
                w_dark        = r_act_blank[k];
                w_sel_mask[k] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_idx_nxt   = r_idx;
        w_nib_nxt   = r_seg_nib;
        w_en_nxt    = 1'b0;
        w_sel_nxt   = '1;
        w_fd_nxt    = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (w_last_blank) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                    w_en_nxt    = 1'b1;
                    w_nib_nxt   = w_nib;
                end
            end
            ST_SHOW: begin
                if (w_last_show) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = w_idx_last ? '0 : r_idx + IW'(1);
                    w_fd_nxt    = w_idx_last;
                end else begin
                    w_sel_nxt   = w_dark ? '1 : w_sel_mask;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_seg_nib    <= 4'h0;
            r_seg_en     <= 1'b0;
            r_dig_sel_n  <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_seg_nib    <= w_nib_nxt;
            r_seg_en     <= w_en_nxt;
            r_dig_sel_n  <= w_sel_nxt;
            r_frame_done <= w_fd_nxt;
        end
    end

    // Double buffer: a strobe on the boundary cycle bypasses the shadow so it
    // shows in the very next frame; otherwise the shadow is promoted there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_data  <= '0;
            r_act_blank <= '0;
            r_shd_data  <= '0;
            r_shd_blank <= '0;
            r_pending   <= 1'b0;
        end else if (w_boundary) begin
            r_pending <= 1'b0;
            if (bus.in_valid) begin
                r_act_data  <= bus.in_data;
                r_act_blank <= bus.in_blank;
                r_shd_data  <= bus.in_data;
                r_shd_blank <= bus.in_blank;
            end else if (r_pending) begin
                r_act_data  <= r_shd_data;
                r_act_blank <= r_shd_blank;
            end
        end else if (bus.in_valid) begin
            r_shd_data  <= bus.in_data;
            r_shd_blank <= bus.in_blank;
            r_pending   <= 1'b1;
        end
    end

    assign bus.seg_nib    = r_seg_nib;
    assign bus.seg_en     = r_seg_en;
    assign bus.dig_sel_n  = r_dig_sel_n;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seg7_scan_ctrl_if #(.P_DIGITS(ND)) bus ();

    seg7_scan_ctrl #(.P_DIGITS(ND), .P_DWELL(4), .P_BLANK(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n_pos cycles of a frame (slot=6: BLANK pos 0-1, seg_en at 2, lit 3-5).
    // Up to two strobes are issued on the given frame positions (-1 = none).
    task automatic frame(input logic [15:0] exp_d, input logic [3:0] exp_b, input bit first,
                         input int n_pos,
                         input int s1, input logic [15:0] d1, input logic [3:0] b1,
                         input int s2, input logic [15:0] d2, input logic [3:0] b2);
        logic [15:0] dd;
        dd = exp_d;
        for (int p = 0; p < n_pos; p++) begin
            int d, r;
            d = p / 6;
            r = p % 6;
            chk("frame_done", {31'd0, bus.frame_done}, {31'd0, (p == 0) && !first});
            chk("seg_en", {31'd0, bus.seg_en}, {31'd0, r == 2});
            if (r >= 2)
                chk("seg_nib", {28'd0, bus.seg_nib}, {28'd0, dd[4*d +: 4]});
            if (r >= 3 && !exp_b[d])
                chk("dig_sel_n", {28'd0, bus.dig_sel_n}, {28'd0, ~(4'b0001 << d)});
            else
                chk("dig_sel_n", {28'd0, bus.dig_sel_n}, 32'hF);
            if (p == s1) begin
                bus.in_valid = 1'b1; bus.in_data = d1; bus.in_blank = b1;
            end
            if (p == s2) begin
                bus.in_valid = 1'b1; bus.in_data = d2; bus.in_blank = b2;
            end
            tick();
            bus.in_valid = 1'b0;
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_blank = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dig_sel_n", {28'd0, bus.dig_sel_n}, 32'hF);
        chk("rst_seg_en", {31'd0, bus.seg_en}, 32'd0);
        chk("rst_seg_nib", {28'd0, bus.seg_nib}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Frame 1: reset value 0, no frame_done before cycle 24.
        frame(16'h0000, 4'b0000, 1'b1, 24, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // Frame 2: still old data; strobe 1A2F mid-frame.
        frame(16'h0000, 4'b0000, 1'b0, 24, 7, 16'h1A2F, 4'h0, -1, 16'h0, 4'h0);
        // Frame 3: 1A2F; two strobes, last one wins.
        frame(16'h1A2F, 4'b0000, 1'b0, 24, 3, 16'h1111, 4'h0, 15, 16'h2222, 4'h0);
        // Frame 4: 2222; strobe BEEF on the boundary cycle.
        frame(16'h2222, 4'b0000, 1'b0, 24, 23, 16'hBEEF, 4'h0, -1, 16'h0, 4'h0);
        // Frame 5: BEEF immediately; request upper digits dark.
        frame(16'hBEEF, 4'b0000, 1'b0, 24, 10, 16'hBEEF, 4'b1100, -1, 16'h0, 4'h0);
        // Frame 6: digits 2,3 dark; queue 5678 for the next frame.
        frame(16'hBEEF, 4'b1100, 1'b0, 24, 5, 16'h5678, 4'h0, -1, 16'h0, 4'h0);
        // Frame 7: run into the SHOW phase of digit 2, then reset asynchronously.
        frame(16'h5678, 4'b0000, 1'b0, 15, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        chk("pre_rst_dig_sel_n", {28'd0, bus.dig_sel_n}, 32'hB);
        // Queue a pending value that reset must discard.
        bus.in_valid = 1'b1; bus.in_data = 16'h9999; bus.in_blank = 4'h0;
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dig_sel_n", {28'd0, bus.dig_sel_n}, 32'hF);
        chk("async_rst_seg_en", {31'd0, bus.seg_en}, 32'd0);
        chk("async_rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Restart at digit 0 with data 0.
        frame(16'h0000, 4'b0000, 1'b1, 24, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        chk("restart_frame_done", {31'd0, bus.frame_done}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end
endmodule
